// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the 2-read/1-write register file with
// background clear.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Background clear sequencer: walks a pointer across every register index,
// one per cycle, and emits a one-hot clear strobe for the index being zeroed.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy_o,
  output logic [(2**ADDR_W)-1:0]   clr_strb_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_strb_o = '0;
    case (state_q)
      IDLE: begin
        if (clear) state_d = CLEAR;
      end
      CLEAR: begin
        clr_strb_o = DEPTH'(1) << ptr_q;
        // The pointer wraps to 0 naturally on the last index.
        ptr_d      = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == CLEAR);

endmodule

// File: rtl/regfile_2r1w_clr.sv
// Parametrised register file: one write port, two combinational read ports,
// per-register valid bits and a background clear sweep.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_2r1w_clr
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_a,
  output logic              valid_b,
  input  logic              clear,
  output logic              busy,
  output logic              write_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  clr_strb;
  logic              busy_w;
  logic              wr_acc;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .busy_o     (busy_w),
    .clr_strb_o (clr_strb)
  );

  assign busy       = busy_w;
  assign wr_acc     = write & ~busy_w;
  assign write_drop = write & busy_w;

  // Clear strobes only fire while busy and writes only land while idle,
  // so the two never target the same cycle.
  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_strb[i]) begin
        regs_d[i]  = '0;
        valid_d[i] = 1'b0;
      end else if (wr_acc && (writenum == ADDR_W'(i))) begin
        regs_d[i]  = data_in;
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      valid_q <= '0;
    end else begin
      regs_q  <= regs_d;
      valid_q <= valid_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    data_out_a = regs_q[readnum_a];
    valid_a    = valid_q[readnum_a];
    data_out_b = regs_q[readnum_b];
    valid_b    = valid_q[readnum_b];
    if (wr_acc && (readnum_a == writenum)) begin
      data_out_a = data_in;
      valid_a    = 1'b1;
    end
    if (wr_acc && (readnum_b == writenum)) begin
      data_out_b = data_in;
      valid_b    = 1'b1;
    end
  end
`else
  assign data_out_a = regs_q[readnum_a];
  assign valid_a    = valid_q[readnum_a];
  assign data_out_b = regs_q[readnum_b];
  assign valid_b    = valid_q[readnum_b];
`endif

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Self-checking bench for regfile_2r1w_clr: directed scenarios followed by
// random traffic, all compared against a behavioural model of the register file.
module tb_regfile_2r1w_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic [15:0] data_out_a;
  logic [15:0] data_out_b;
  logic        valid_a;
  logic        valid_b;
  logic        clear;
  logic        busy;
  logic        write_drop;

  int checks   = 0;
  int failures = 0;

  // Behavioural model
  logic [15:0] m_mem [8];
  bit          m_vld [8];
  bit          m_busy;
  int          m_sweep;   // index the sweep clears next

  always #5 clk = ~clk;

  regfile_2r1w_clr dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .writenum   (writenum),
    .write      (write),
    .readnum_a  (readnum_a),
    .readnum_b  (readnum_b),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .valid_a    (valid_a),
    .valid_b    (valid_b),
    .clear      (clear),
    .busy       (busy),
    .write_drop (write_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 16'h0;
      m_vld[i] = 1'b0;
    end
    m_busy  = 1'b0;
    m_sweep = 0;
  endtask

  function automatic logic [16:0] model_read(input logic [2:0] idx);
    bit fwd;
    fwd = 1'b0;
`ifdef REGFILE_BYPASS_EN
    fwd = write && !m_busy && (idx == writenum);
`endif
    if (fwd) return {1'b1, data_in};
    return {m_vld[idx], m_mem[idx]};
  endfunction

  // Drive one cycle, check combinational outputs mid-cycle, then advance the model.
  task automatic cyc(input bit rst, input bit clr, input bit wr, input logic [2:0] wn,
                     input logic [15:0] d, input logic [2:0] ra, input logic [2:0] rb);
    logic [16:0] ea, eb;
    reset = rst; clear = clr; write = wr; writenum = wn; data_in = d;
    readnum_a = ra; readnum_b = rb;
    @(negedge clk);
    ea = model_read(ra);
    eb = model_read(rb);
    chk("data_a",  32'(data_out_a), 32'(ea[15:0]));
    chk("valid_a", 32'(valid_a),    32'(ea[16]));
    chk("data_b",  32'(data_out_b), 32'(eb[15:0]));
    chk("valid_b", 32'(valid_b),    32'(eb[16]));
    chk("busy",    32'(busy),       32'(m_busy));
    chk("wdrop",   32'(write_drop), 32'(wr && m_busy));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      m_mem[m_sweep] = 16'h0;
      m_vld[m_sweep] = 1'b0;
      if (m_sweep == 7) begin
        m_busy  = 1'b0;
        m_sweep = 0;
      end else begin
        m_sweep++;
      end
    end else begin
      if (wr) begin
        m_mem[wn] = d;
        m_vld[wn] = 1'b1;
      end
      if (clr) m_busy = 1'b1;
    end
    #1;
  endtask

  initial begin
    // Initial reset cycle: DUT state unknown before this edge, so no checks.
    reset = 1'b1; clear = 1'b0; write = 1'b0; writenum = '0; data_in = '0;
    readnum_a = '0; readnum_b = '0;
    @(posedge clk);
    model_reset();
    #1;

    // Reset state on every index, both ports
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
    chk("rst_busy_direct", 32'(busy), 32'(0));

    // Dual read
    cyc(0, 0, 1, 3'd2, 16'h1234, 3'd0, 3'd1);
    cyc(0, 0, 1, 3'd5, 16'hBEEF, 3'd2, 3'd5);
    cyc(0, 0, 0, 0, 0, 3'd2, 3'd5);
    chk("dual_a_direct", 32'(data_out_a), 32'h1234);
    chk("dual_b_direct", 32'(data_out_b), 32'hBEEF);
    cyc(0, 0, 0, 0, 0, 3'd5, 3'd5);

    // Fill, clear sweep with a dropped write on sweep cycle 3
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 3'(i), 16'hA000 + 16'(i), 3'(i), 3'd7);
    cyc(0, 1, 0, 0, 0, 3'd0, 3'd7);
    for (int k = 0; k < 8; k++) begin
      cyc(0, (k == 2), (k == 3), 3'd7, 16'hAAAA, 3'(k), 3'((k + 1) % 8));
      if (k == 3) chk("drop_direct", 32'(write_drop), 32'(1));
    end
    cyc(0, 0, 0, 0, 0, 3'd7, 3'd0);
    chk("sweep_done_busy", 32'(busy), 32'(0));
    chk("r7_cleared", 32'(data_out_a), 32'h0);

    // Reset mid-sweep, then a normal write
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 3'(i), 16'h5A00 + 16'(i), 3'(i), 3'd6);
    cyc(0, 1, 0, 0, 0, 3'd6, 3'd7);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 3'd6, 3'd7);
    cyc(1, 0, 0, 0, 0, 3'd6, 3'd7);
    cyc(0, 0, 0, 0, 0, 3'd6, 3'd7);
    cyc(0, 0, 1, 3'd1, 16'h0055, 3'd1, 3'd6);
    cyc(0, 0, 0, 0, 0, 3'd1, 3'd1);

    // Forwarding (or its absence) on a same-index read during a write
    cyc(0, 0, 1, 3'd3, 16'h1111, 3'd3, 3'd0);
    cyc(0, 0, 1, 3'd3, 16'h00FF, 3'd3, 3'd3);
    cyc(0, 0, 0, 0, 0, 3'd3, 3'd3);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
          1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
